// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state codes, PC defaults, instruction width and NOP encoding.
// Also defines the packed IF/ID entry type and the word-alignment helper used for redirect targets.
package cpu_pkg;

    localparam int INSTR_W = 32;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;

    // ADDI x0,x0,0 -- what ID substitutes for an invalid IF/ID entry
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;
    localparam fetch_state_t ST_REDIR = 2'd3;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } ifid_ent_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {instr, pc} buffer that parks a fetched word while ID is stalled.
// Load wins over drop; contents persist until the next load and only the valid bit is cleared on drop.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_load,
    input  logic      i_drop,
    input  ifid_ent_t i_ent,
    output logic      o_vld,
    output ifid_ent_t o_ent
);

    logic      r_vld;
    ifid_ent_t r_ent;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_ent <= '0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_ent <= i_ent;
        end else if (i_drop) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld = r_vld;
    assign o_ent = r_ent;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the imem request/ready handshake and drives the IF/ID register.
// Redirects discard in-flight words; a stall parks at most one word in the skid and stops requesting.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCSrc,
    input  logic [31:0]        pc_imm,
    input  logic               stall,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [31:0]        pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_redir_pc;
    logic [31:0]  w_redir_nxt;
    logic         r_if_vld;
    logic         w_if_vld_nxt;
    ifid_ent_t    r_ifid;
    ifid_ent_t    w_ifid_nxt;

    logic         w_skid_load;
    logic         w_skid_drop;
    logic         w_skid_vld;
    ifid_ent_t    w_skid_in;
    ifid_ent_t    w_skid_ent;
    logic [31:0]  w_target;

    assign w_target       = align_word(pc_imm);
    assign w_skid_in.instr = imem_rdata;
    assign w_skid_in.pc    = r_pc;

    fetch_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_skid_load),
        .i_drop (w_skid_drop),
        .i_ent  (w_skid_in),
        .o_vld  (w_skid_vld),
        .o_ent  (w_skid_ent)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_redir_nxt  = r_redir_pc;
        w_ifid_nxt   = r_ifid;
        w_skid_load  = 1'b0;
        w_skid_drop  = 1'b0;
        // Flush beats hold beats bubble; a delivery below overrides the bubble
        if (PCSrc)
            w_if_vld_nxt = 1'b0;
        else if (stall)
            w_if_vld_nxt = r_if_vld;
        else
            w_if_vld_nxt = 1'b0;

        case (r_state)
            ST_IDLE: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (PCSrc) begin
                    if (imem_ready) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_redir_nxt = w_target;
                        w_state_nxt = ST_REDIR;
                    end
                end else if (imem_ready) begin
                    w_pc_nxt = r_pc + PC_STEP;
                    if (stall) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_if_vld_nxt     = 1'b1;
                        w_ifid_nxt.instr = imem_rdata;
                        w_ifid_nxt.pc    = r_pc;
                    end
                end
            end
            ST_HOLD: begin
                if (PCSrc) begin
                    w_skid_drop = 1'b1;
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_FETCH;
                end else if (!stall) begin
                    w_skid_drop  = 1'b1;
                    w_if_vld_nxt = w_skid_vld;
                    w_ifid_nxt   = w_skid_ent;
                    w_state_nxt  = ST_FETCH;
                end
            end
            ST_REDIR: begin
                // The address stays on the old PC until memory accepts, then the freshest target wins
                if (imem_ready) begin
                    w_pc_nxt    = PCSrc ? w_target : r_redir_pc;
                    w_state_nxt = ST_FETCH;
                end else if (PCSrc) begin
                    w_redir_nxt = w_target;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_redir_pc <= '0;
            r_if_vld   <= 1'b0;
            r_ifid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_redir_pc <= w_redir_nxt;
            r_if_vld   <= w_if_vld_nxt;
            r_ifid     <= w_ifid_nxt;
        end
    end

    assign imem_req  = (r_state == ST_FETCH) || (r_state == ST_REDIR);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign if_valid  = r_if_vld;
    assign if_instr  = r_ifid.instr;
    assign if_pc     = r_ifid.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed phases push expected IF/ID PCs, a negedge monitor pops them.
// Memory model answers addr ^ A5A5_A5A5 after a programmable number of wait cycles.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        PCSrc      = 1'b0;
    logic [31:0] pc_imm     = 32'h0;
    logic        stall      = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;
    int          mem_wait = 0;
    int          mem_cnt  = 0;
    logic        edge_rst   = 1'b1;
    logic        edge_stall = 1'b0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrc      (PCSrc),
        .pc_imm     (pc_imm),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory: ready once the current request has waited mem_wait cycles
    always begin
        @(negedge clk);
        #1;
        imem_ready = imem_req && (mem_cnt >= mem_wait);
        imem_rdata = imem_addr ^ KEY;
    end

    always @(posedge clk) begin
        edge_rst   <= rst;
        edge_stall <= stall;
        if (imem_req && !imem_ready) mem_cnt <= mem_cnt + 1;
        else                         mem_cnt <= 0;
    end

    // A held entry under stall is not a new delivery
    always @(negedge clk) begin
        if (!edge_rst && !edge_stall && if_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word: got pc %h want none", if_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("if_pc", if_pc, mon_e);
                check("if_instr", if_instr, mon_e ^ KEY);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input int w);
        rst = 1'b1; PCSrc = 1'b0; stall = 1'b0; pc_imm = 32'h0; mem_wait = w;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        #1;
        check(name, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        // reset state
        cyc(2);
        check("rst_pc", pc, 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(if_valid), 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_ifpc", if_pc, 32'h0);
        check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

        // zero-wait streaming
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        start(0);
        cyc(1);
        check("p1_e1_valid", 32'(if_valid), 32'h0);
        check("p1_e1_req", 32'(imem_req), 32'h1);
        cyc(1);
        check("p1_e2_valid", 32'(if_valid), 32'h1);
        cyc(7);
        drain("p1_drain");

        // three wait cycles per fetch
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        start(3);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("p2_addr_hold", imem_addr, 32'h0);
            check("p2_req", 32'(imem_req), 32'h1);
            check("p2_wait_valid", 32'(if_valid), 32'h0);
        end
        cyc(1);
        check("p2_pulse", 32'(if_valid), 32'h1);
        cyc(1);
        check("p2_bubble", 32'(if_valid), 32'h0);
        cyc(7);
        drain("p2_drain");

        // stall while word for 0x8 returns
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC); exp_q.push_back(32'h10);
        start(0);
        cyc(3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("p3_state_hold", 32'(dut.r_state), 32'(ST_HOLD));
            check("p3_req_off", 32'(imem_req), 32'h0);
            check("p3_ifpc_held", if_pc, 32'h4);
            check("p3_pc_frozen", pc, 32'hC);
        end
        stall = 1'b0;
        cyc(1);
        check("p3_release_pc", if_pc, 32'h8);
        cyc(2);
        drain("p3_drain");

        // redirect while request to 0x10 waits
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC); exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        start(0);
        cyc(5);
        check("p4_addr10", imem_addr, 32'h10);
        mem_wait = 3; PCSrc = 1'b1; pc_imm = 32'h103;
        cyc(1);
        PCSrc = 1'b0;
        check("p4_state_redir", 32'(dut.r_state), 32'(ST_REDIR));
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc(1);
            check("p4_addr_held", imem_addr, 32'h10);
            check("p4_req", 32'(imem_req), 32'h1);
            check("p4_flush", 32'(if_valid), 32'h0);
        end
        cyc(1);
        mem_wait = 0;
        check("p4_target", imem_addr, 32'h100);
        check("p4_no_valid", 32'(if_valid), 32'h0);
        cyc(2);
        drain("p4_drain");

        // PCSrc and stall together from HOLD
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h200); exp_q.push_back(32'h204);
        start(0);
        cyc(3);
        stall = 1'b1;
        cyc(1);
        check("p5_hold", 32'(dut.r_state), 32'(ST_HOLD));
        PCSrc = 1'b1; pc_imm = 32'h200;
        cyc(1);
        PCSrc = 1'b0; stall = 1'b0;
        check("p5_flush", 32'(if_valid), 32'h0);
        check("p5_skid_drop", 32'(dut.u_skid.r_vld), 32'h0);
        check("p5_target", imem_addr, 32'h200);
        check("p5_req", 32'(imem_req), 32'h1);
        cyc(2);
        drain("p5_drain");

        // PC wrap, then reset during a wait
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        start(0);
        cyc(1);
        PCSrc = 1'b1; pc_imm = 32'hFFFF_FFFC;
        cyc(1);
        PCSrc = 1'b0;
        check("p6_redir_valid", 32'(if_valid), 32'h0);
        check("p6_pc_top", pc, 32'hFFFF_FFFC);
        cyc(1);
        check("p6_wrap", pc, 32'h0);
        cyc(2);
        mem_wait = 3;
        cyc(1);
        check("p6_wait_req", 32'(imem_req), 32'h1);
        check("p6_wait_addr", imem_addr, 32'h8);
        rst = 1'b1;
        cyc(1);
        check("p6_rst_req", 32'(imem_req), 32'h0);
        check("p6_rst_pc", pc, 32'h0);
        check("p6_rst_valid", 32'(if_valid), 32'h0);
        check("p6_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        drain("p6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
